asteroid_field_move: RTL and testbench

ASTEROID_FIELD_MOVE -- requirements
Module: asteroid_field_move

---
 rtl/asteroid_field_move_if.sv | 28 ++
 rtl/asteroid_field_move.sv | 165 ++++++++++++++++
 tb/tb_asteroid_field_move.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/asteroid_field_move_if.sv
// Control/status bundle for asteroid_field_move: frame strobe, collision inputs, per-channel
// coordinates and status. Channel i occupies slice i of every packed vector.
interface asteroid_field_move_if #(
    parameter int N_AST       = 4,
    parameter int PIXEL_WIDTH = 11
);
    logic                         startOfFrame;
    logic [1:0]                   speed_sel;
    logic [N_AST-1:0]             player_collision;
    logic [N_AST-1:0]             border_collision;
    logic [4*N_AST-1:0]           HitEdgeCode;
    logic [N_AST*PIXEL_WIDTH-1:0] topLeftX;
    logic [N_AST*PIXEL_WIDTH-1:0] topLeftY;
    logic [N_AST-1:0]             asteroidActive;
    logic [N_AST-1:0]             asteroidIsHit;
    logic [7:0]                   hit_count;
    logic                         all_down;

    modport master (
        output startOfFrame, speed_sel, player_collision, border_collision, HitEdgeCode,
        input  topLeftX, topLeftY, asteroidActive, asteroidIsHit, hit_count, all_down
    );

    modport slave (
        input  startOfFrame, speed_sel, player_collision, border_collision, HitEdgeCode,
        output topLeftX, topLeftY, asteroidActive, asteroidIsHit, hit_count, all_down
    );
endinterface

// File: rtl/asteroid_field_move.sv
// Asteroid field mover: N_AST independent MOVING/HIT/WAIT channels with fixed-point motion.
// Define ASTEROID_WRAP_EN to wrap X on outward left/right border hits instead of respawning.
module asteroid_field_move #(
    parameter int N_AST          = 4,
    parameter int PIXEL_WIDTH    = 11,
    parameter int FRAC_BITS      = 6,
    parameter int X_SPEED        = 8,
    parameter int Y_SPEED        = 0,
    parameter int INITIAL_X      = 50,
    parameter int INITIAL_Y      = 50,
    parameter int Y_SPACING      = 40,
    parameter int HIT_FRAMES     = 8,
    parameter int RESPAWN_FRAMES = 30,
    parameter int WRAP_MIN_X     = 0,
    parameter int WRAP_MAX_X     = 639
) (
    input logic                  clk,
    input logic                  reset,
    asteroid_field_move_if.slave af
);
    localparam int PosW   = PIXEL_WIDTH + FRAC_BITS;
    localparam int MaxCnt = (HIT_FRAMES > RESPAWN_FRAMES) ? HIT_FRAMES : RESPAWN_FRAMES;
    localparam int CntW   = (MaxCnt < 2) ? 1 : $clog2(MaxCnt + 1);

    localparam logic signed [PosW-1:0] SpawnX   = PosW'(INITIAL_X <<< FRAC_BITS);
    localparam logic signed [PosW-1:0] WrapMinX = PosW'(WRAP_MIN_X <<< FRAC_BITS);
    localparam logic signed [PosW-1:0] WrapMaxX = PosW'(WRAP_MAX_X <<< FRAC_BITS);

`ifdef ASTEROID_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StMoving, StHit, StWait} state_e;

    state_e                 state_q [N_AST];
    state_e                 state_d [N_AST];
    logic signed [PosW-1:0] x_q     [N_AST];
    logic signed [PosW-1:0] x_d     [N_AST];
    logic signed [PosW-1:0] y_q     [N_AST];
    logic signed [PosW-1:0] y_d     [N_AST];
    logic signed [15:0]     xs_q    [N_AST];
    logic signed [15:0]     xs_d    [N_AST];
    logic signed [15:0]     ys_q    [N_AST];
    logic signed [15:0]     ys_d    [N_AST];
    logic [CntW-1:0]        cnt_q   [N_AST];
    logic [CntW-1:0]        cnt_d   [N_AST];
    logic [7:0]             hit_count_q, hit_count_d;

    function automatic logic signed [PosW-1:0] spawn_y(input int idx);
        return PosW'((INITIAL_Y + idx * Y_SPACING) <<< FRAC_BITS);
    endfunction

    function automatic logic signed [15:0] scale_speed(input int base, input logic [1:0] sel);
        return 16'(base <<< sel);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_AST; i++) begin
                state_q[i] <= StMoving;
                x_q[i]     <= SpawnX;
                y_q[i]     <= spawn_y(i);
                xs_q[i]    <= scale_speed(X_SPEED, 2'd0);
                ys_q[i]    <= scale_speed(Y_SPEED, 2'd0);
                cnt_q[i]   <= '0;
            end
            hit_count_q <= '0;
        end else begin
            for (int i = 0; i < N_AST; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                xs_q[i]    <= xs_d[i];
                ys_q[i]    <= ys_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            hit_count_q <= hit_count_d;
        end
    end

    always_comb begin
        int   n_hit;
        logic out_l, out_r, out_t, out_b, do_spawn;
        n_hit = 0;
        for (int i = 0; i < N_AST; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            xs_d[i]    = xs_q[i];
            ys_d[i]    = ys_q[i];
            cnt_d[i]   = cnt_q[i];
            do_spawn   = 1'b0;
            // An edge only counts when the channel is heading out through it
            out_l = af.HitEdgeCode[4*i+3] && (xs_q[i] < 0);
            out_t = af.HitEdgeCode[4*i+2] && (ys_q[i] < 0);
            out_r = af.HitEdgeCode[4*i+1] && (xs_q[i] > 0);
            out_b = af.HitEdgeCode[4*i]   && (ys_q[i] > 0);
            unique case (state_q[i])
                StMoving: begin
                    if (af.player_collision[i]) begin
                        state_d[i] = StHit;
                        cnt_d[i]   = '0;
                        n_hit++;
                    end else if (af.border_collision[i] && (out_l || out_r || out_t || out_b)) begin
                        if (WrapEn && !(out_t || out_b)) begin
                            x_d[i] = out_l ? WrapMaxX : WrapMinX;
                        end else begin
                            do_spawn = 1'b1;
                        end
                    end else if (af.startOfFrame) begin
                        x_d[i] = x_q[i] + PosW'(xs_q[i]);
                        y_d[i] = y_q[i] + PosW'(ys_q[i]);
                    end
                end
                StHit: begin
                    if (af.startOfFrame) begin
                        if (int'(cnt_q[i]) + 1 >= HIT_FRAMES) begin
                            cnt_d[i] = '0;
                            if (RESPAWN_FRAMES == 0) do_spawn = 1'b1;
                            else state_d[i] = StWait;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CntW'(1);
                        end
                    end
                end
                StWait: begin
                    if (af.startOfFrame) begin
                        if (int'(cnt_q[i]) + 1 >= RESPAWN_FRAMES) do_spawn = 1'b1;
                        else cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                default: state_d[i] = StMoving;
            endcase
            if (do_spawn) begin
                state_d[i] = StMoving;
                cnt_d[i]   = '0;
                x_d[i]     = SpawnX;
                y_d[i]     = spawn_y(i);
                xs_d[i]    = scale_speed(X_SPEED, af.speed_sel);
                ys_d[i]    = scale_speed(Y_SPEED, af.speed_sel);
            end
        end
        if (int'(hit_count_q) + n_hit > 255) hit_count_d = 8'd255;
        else hit_count_d = 8'(int'(hit_count_q) + n_hit);
    end

    always_comb begin
        af.topLeftX       = '0;
        af.topLeftY       = '0;
        af.asteroidActive = '0;
        af.asteroidIsHit  = '0;
        af.all_down       = 1'b1;
        for (int i = 0; i < N_AST; i++) begin
            af.topLeftX[i*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(x_q[i] >>> FRAC_BITS);
            af.topLeftY[i*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(y_q[i] >>> FRAC_BITS);
            af.asteroidActive[i] = (state_q[i] == StMoving);
            af.asteroidIsHit[i]  = (state_q[i] == StHit);
            if (state_q[i] == StMoving) af.all_down = 1'b0;
        end
    end

    assign af.hit_count = hit_count_q;
endmodule

// File: tb/tb_asteroid_field_move.sv
// Directed bench for asteroid_field_move: default 4-channel instance plus a 1-channel
// negative-speed instance with zero respawn delay.
module tb_asteroid_field_move;
    localparam int PW = 11;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    asteroid_field_move_if #(.N_AST(4), .PIXEL_WIDTH(PW)) af ();
    asteroid_field_move_if #(.N_AST(1), .PIXEL_WIDTH(PW)) bf ();

    asteroid_field_move dut (
        .clk   (clk),
        .reset (reset),
        .af    (af)
    );

    asteroid_field_move #(
        .N_AST          (1),
        .X_SPEED        (-1),
        .INITIAL_X      (0),
        .HIT_FRAMES     (2),
        .RESPAWN_FRAMES (0)
    ) dut_neg (
        .clk   (clk),
        .reset (reset),
        .af    (bf)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ax(input int i);
        return int'(signed'(af.topLeftX[i*PW +: PW]));
    endfunction

    function automatic int ay(input int i);
        return int'(signed'(af.topLeftY[i*PW +: PW]));
    endfunction

    function automatic int bx();
        return int'(signed'(bf.topLeftX[PW-1:0]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            af.startOfFrame = 1'b1;
            bf.startOfFrame = 1'b1;
            tick();
            af.startOfFrame = 1'b0;
            bf.startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic hit_b();
        bf.player_collision = 1'b1;
        tick();
        bf.player_collision = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        af.startOfFrame = 1'b0;  af.speed_sel = 2'd0;  af.player_collision = '0;
        af.border_collision = '0;  af.HitEdgeCode = '0;
        bf.startOfFrame = 1'b0;  bf.speed_sel = 2'd0;  bf.player_collision = '0;
        bf.border_collision = '0;  bf.HitEdgeCode = '0;
        #2;
        check_eq("rst_x0", ax(0), 50);
        check_eq("rst_y0", ay(0), 50);
        check_eq("rst_y1", ay(1), 90);
        check_eq("rst_y2", ay(2), 130);
        check_eq("rst_y3", ay(3), 170);
        check_eq("rst_active", int'(af.asteroidActive), 15);
        check_eq("rst_ishit", int'(af.asteroidIsHit), 0);
        check_eq("rst_hitcnt", int'(af.hit_count), 0);
        check_eq("rst_alldown", int'(af.all_down), 0);
        check_eq("rst_bx", bx(), 0);

        @(negedge clk);
        reset = 1'b0;
        frames(1);
        check_eq("neg_frac_x", bx(), -1);
        check_eq("x0_1frame", ax(0), 50);

        // Leftward channel hitting the left edge
        bf.border_collision = 1'b1;
        bf.HitEdgeCode      = 4'b1000;
        tick();
        bf.border_collision = 1'b0;
        bf.HitEdgeCode      = '0;
`ifdef ASTEROID_WRAP_EN
        check_eq("b_left_wrap", bx(), 639);
`else
        check_eq("b_left_respawn", bx(), 0);
`endif

        frames(7);
        check_eq("x0_8frames", ax(0), 51);
        frames(56);
        check_eq("x0_64frames", ax(0), 58);
        check_eq("y0_64frames", ay(0), 50);

        // Single hit on channel 1: 8 frames HIT, 30 frames WAIT, respawn
        af.player_collision = 4'b0010;
        tick();
        af.player_collision = '0;
        check_eq("hit1_ishit", int'(af.asteroidIsHit), 2);
        check_eq("hit1_active", int'(af.asteroidActive), 13);
        check_eq("hit1_cnt", int'(af.hit_count), 1);
        frames(7);
        check_eq("hit1_7f_ishit", int'(af.asteroidIsHit), 2);
        check_eq("hit1_frozen_x", ax(1), 58);
        frames(1);
        check_eq("wait1_ishit", int'(af.asteroidIsHit), 0);
        check_eq("wait1_active", int'(af.asteroidActive), 13);
        frames(29);
        check_eq("wait1_29f_active", int'(af.asteroidActive), 13);
        frames(1);
        check_eq("respawn1_active", int'(af.asteroidActive), 15);
        check_eq("respawn1_x", ax(1), 50);
        check_eq("respawn1_y", ay(1), 90);
        check_eq("x0_102frames", ax(0), 62);

        // Simultaneous hits, then a repeat hit during HIT
        af.player_collision = 4'b0101;
        tick();
        af.player_collision = '0;
        check_eq("dual_hitcnt", int'(af.hit_count), 3);
        check_eq("dual_ishit", int'(af.asteroidIsHit), 5);
        af.player_collision = 4'b0001;
        tick();
        af.player_collision = '0;
        check_eq("rehit_hitcnt", int'(af.hit_count), 3);

        // Respawn with speed_sel=2 gives 32/64 px per frame
        af.speed_sel = 2'd2;
        frames(37);
        check_eq("dual_wait_active", int'(af.asteroidActive), 10);
        frames(1);
        check_eq("dual_resp_active", int'(af.asteroidActive), 15);
        check_eq("fast_x0_0", ax(0), 50);
        frames(1);
        check_eq("fast_x0_1", ax(0), 50);
        frames(1);
        check_eq("fast_x0_2", ax(0), 51);
        af.speed_sel = 2'd0;

        af.player_collision = 4'b1111;
        tick();
        af.player_collision = '0;
        check_eq("all_hit_down", int'(af.all_down), 1);
        check_eq("all_hit_cnt", int'(af.hit_count), 7);
        check_eq("all_hit_active", int'(af.asteroidActive), 0);
        frames(38);
        check_eq("all_back_down", int'(af.all_down), 0);
        check_eq("all_back_active", int'(af.asteroidActive), 15);

        frames(16);
        check_eq("x0_pre_border", ax(0), 52);
        // ch0: right edge while moving right; ch1: left edge while moving right (ignored)
        af.border_collision = 4'b0011;
        af.HitEdgeCode      = 16'h0082;
        af.startOfFrame     = 1'b1;
        tick();
        af.border_collision = '0;
        af.HitEdgeCode      = '0;
        af.startOfFrame     = 1'b0;
`ifdef ASTEROID_WRAP_EN
        check_eq("border_x0_wrap", ax(0), 0);
`else
        check_eq("border_x0_respawn", ax(0), 50);
`endif
        check_eq("border_y0", ay(0), 50);
        check_eq("border_ignored_x1", ax(1), 52);

        // Zero respawn delay: HIT goes straight back to MOVING
        hit_b();
        check_eq("b_ishit", int'(bf.asteroidIsHit), 1);
        check_eq("b_hitcnt", int'(bf.hit_count), 1);
        frames(1);
        check_eq("b_ishit_1f", int'(bf.asteroidIsHit), 1);
        frames(1);
        check_eq("b_active_2f", int'(bf.asteroidActive), 1);
        check_eq("b_ishit_2f", int'(bf.asteroidIsHit), 0);
        check_eq("b_respawn_x", bx(), 0);
        frames(1);
        check_eq("b_neg_again", bx(), -1);

        repeat (253) begin
            hit_b();
            frames(2);
        end
        check_eq("b_hitcnt_254", int'(bf.hit_count), 254);
        repeat (46) begin
            hit_b();
            frames(2);
        end
        check_eq("b_hitcnt_sat", int'(bf.hit_count), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
